in_port_rc10: RTL and testbench
===============================

IN_PORT_RC10 -- requirements
Module: in_port_rc10

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two).
REQ-002 SHALL have parameter WIDTH, default 3, pointer width, log2(DEPTH).
REQ-003 SHALL have parameter DATASIZE, default 40, flit width: src[39:36], dst[35:32] (x=[35:34], y=[33:32]), timestamp[31:24], data[23:2], type[1:0].
REQ-004 SHALL have parameters X_POS and Y_POS, default 1 and 0, 2-bit router coordinates.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  DATASIZE  flit from upstream link.
REQ-008 data_valid  input  1  upstream flit valid this cycle.
REQ-009 full  output  1  buffer full; upstream must not send.
REQ-010 data_out  output  DATASIZE  head flit to switch allocator.
REQ-011 label  output  4  one-hot requested output of head: [0]=L, [1]=N, [2]=E, [3]=S; 0 when empty.
REQ-012 ready  input  1  allocator grant; head consumed this cycle.
REQ-013 count  output  WIDTH+1  current occupancy, 0..DEPTH.
REQ-014 route_err  output  1  sticky: unroutable flit discarded.
REQ-015 ovf_err  output  1  sticky: data_valid seen while full.

Function
REQ-016 SHALL implement a DEPTH-entry circular FIFO with WIDTH-bit write/read pointers wrapping DEPTH-1 -> 0.
REQ-017 Push SHALL occur when data_valid=1 and full=0; flit stored at write pointer, pointer +1.
REQ-018 full SHALL equal (count==DEPTH), registered-state-derived; push with full=1 SHALL be rejected even if a pop occurs that cycle, and SHALL set ovf_err.
REQ-019 Pop SHALL occur when ready=1, count!=0 and label!=0; read pointer +1.
REQ-020 Simultaneous push and pop SHALL leave count unchanged.
REQ-021 data_out SHALL present the head entry first-word-fall-through; a flit pushed in cycle N SHALL appear on data_out in cycle N+1 if buffer was empty; no same-cycle bypass.
REQ-022 ready while count=0 SHALL be ignored.
REQ-023 label SHALL be combinational XY routing from head dst: dst_x>X_POS -> E; dst_x==X_POS and dst_y>Y_POS -> N; dst_x==X_POS and dst_y<Y_POS -> S; dst equal to (X_POS,Y_POS) -> L.
REQ-024 dst_x<X_POS (no W port) SHALL be unroutable: label=0, head auto-popped that cycle regardless of ready, route_err set.
REQ-025 Auto-pop and push in the same cycle SHALL follow REQ-020.
REQ-026 data_out and label SHALL be stable while ready=0 and no auto-pop.
REQ-027 route_err and ovf_err SHALL remain 1 until reset.

Reset
REQ-028 rst=1 at a clock edge SHALL clear pointers, count=0, route_err=0, ovf_err=0; full=0, label=0; data_out=0.
REQ-029 Reset mid-operation SHALL discard all stored flits; push/pop in the reset cycle SHALL be ignored.
REQ-030 Storage array SHALL NOT require reset.

Configuration
REQ-031 Macro IN_PORT_HOPCNT_EN defined: data_out timestamp field SHALL be head timestamp+1, saturating at 255; other fields unchanged.
REQ-032 Macro undefined: data_out SHALL equal stored flit bit-exact.

Verification
REQ-033 Reset, push dst=4'b1000 (x=2,y=0) at X_POS=1,Y_POS=0 -> next cycle count=1, label=4'b0100, data_out=flit.
REQ-034 Push 8 flits, ready=0 -> full=1 after 8th; 9th data_valid rejected, count=8, ovf_err=1.
REQ-035 Full, data_valid=1 and ready=1 same cycle -> pop only, count=7, full=0 next cycle.
REQ-036 Push dst=4'b0000 at X_POS=1 -> label=0, flit discarded without ready, route_err=1, count=0.
REQ-037 Push 20 flits with random ready -> output order matches input, pointers wrap; with IN_PORT_HOPCNT_EN timestamp 8'hFF stays 8'hFF, 8'h05 becomes 8'h06.

Source files
------------

// File: rtl/in_port_rc10.sv
// Router input port: FWFT flit FIFO with XY route computation on the head.
// Optional IN_PORT_HOPCNT_EN: data_out timestamp = head timestamp + 1 (sat).
module in_port_rc10 #(
   parameter int         DEPTH    = 8,
   parameter int         WIDTH    = 3,
   parameter int         DATASIZE = 40,
   parameter logic [1:0] X_POS    = 2'd1,
   parameter logic [1:0] Y_POS    = 2'd0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                data_valid,
   output logic                full,
   output logic [DATASIZE-1:0] data_out,
   output logic [3:0]          label,
   input  logic                ready,
   output logic [WIDTH:0]      count,
   output logic                route_err,
   output logic                ovf_err
);

   localparam logic [WIDTH:0] LP_DEPTH = (WIDTH+1)'(DEPTH);

   logic [DATASIZE-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0]    r_wr_ptr;
   logic [WIDTH-1:0]    r_rd_ptr;
   logic [WIDTH:0]      r_count;
   logic                r_route_err;
   logic                r_ovf_err;

   logic [DATASIZE-1:0] w_head;
   logic                w_nempty;
   logic                w_full;
   logic [1:0]          w_dx;
   logic [1:0]          w_dy;
   logic [3:0]          w_label;
   logic                w_unroute;
   logic                w_push;
   logic                w_pop;
   logic [DATASIZE-1:0] w_out;

   assign w_head   = r_mem[r_rd_ptr];
   assign w_nempty = (r_count != '0);
   assign w_full   = (r_count == LP_DEPTH);
   assign w_dx     = w_head[35:34];
   assign w_dy     = w_head[33:32];

   // XY route of the head flit; no west port, so dst_x < X_POS is unroutable
   always_comb begin
      w_label   = 4'b0000;
      w_unroute = 1'b0;
      if (w_nempty) begin
         if (w_dx < X_POS)
            w_unroute = 1'b1;
         else if (w_dx > X_POS)
            w_label = 4'b0100;
         else if (w_dy > Y_POS)
            w_label = 4'b0010;
         else if (w_dy < Y_POS)
            w_label = 4'b1000;
         else
            w_label = 4'b0001;
      end
   end

   assign w_push = data_valid && !w_full;
   assign w_pop  = w_nempty && (w_unroute || (ready && (w_label != 4'b0000)));

`ifdef IN_PORT_HOPCNT_EN
   logic [7:0] w_ts;
   logic [7:0] w_ts_inc;
   assign w_ts     = w_head[31:24];
   assign w_ts_inc = (w_ts == 8'hFF) ? 8'hFF : w_ts + 8'd1;
   assign w_out    = {w_head[DATASIZE-1:32], w_ts_inc, w_head[23:0]};
`else
   assign w_out    = w_head;
`endif

   assign data_out  = w_nempty ? w_out : '0;
   assign label     = w_label;
   assign full      = w_full;
   assign count     = r_count;
   assign route_err = r_route_err;
   assign ovf_err   = r_ovf_err;

   // Flit storage, written at the write pointer on an accepted push
   always_ff @(posedge clk) begin
      if (!rst && w_push)
         r_mem[r_wr_ptr] <= data_in;
   end

   // Pointers, occupancy and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_route_err <= 1'b0;
         r_ovf_err   <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + WIDTH'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + WIDTH'(1);
         if (w_push && !w_pop)
            r_count <= r_count + (WIDTH+1)'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - (WIDTH+1)'(1);
         if (w_nempty && w_unroute)
            r_route_err <= 1'b1;
         if (data_valid && w_full)
            r_ovf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_in_port_rc10.sv
// Directed + random scoreboard bench for in_port_rc10 (X_POS=1, Y_POS=0).
// Queue model predicts occupancy, head, label, and sticky flags each cycle.
module tb_in_port_rc10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        full;
   logic [39:0] data_out;
   logic [3:0]  label;
   logic        ready = 1'b0;
   logic [3:0]  count;
   logic        route_err;
   logic        ovf_err;

   int tests = 0;
   int fails = 0;

   logic [39:0] q[$];
   logic        m_rerr = 1'b0;
   logic        m_oerr = 1'b0;

   in_port_rc10 dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .full       (full),
      .data_out   (data_out),
      .label      (label),
      .ready      (ready),
      .count      (count),
      .route_err  (route_err),
      .ovf_err    (ovf_err)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] mk(input logic [3:0] dst, input logic [7:0] ts);
      logic [21:0] d;
      d = 22'($urandom);
      return {4'hA, dst, ts, d, 2'b01};
   endfunction

   function automatic logic [3:0] route(input logic [39:0] f);
      logic [1:0] x;
      logic [1:0] y;
      x = f[35:34];
      y = f[33:32];
      if (x < 2'd1) return 4'b0000;
      if (x > 2'd1) return 4'b0100;
      if (y > 2'd0) return 4'b0010;
      return 4'b0001;
   endfunction

   function automatic logic [39:0] expo(input logic [39:0] f);
      logic [39:0] r;
      r = f;
`ifdef IN_PORT_HOPCNT_EN
      if (f[31:24] != 8'hFF) r[31:24] = f[31:24] + 8'd1;
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, "_count"}, 64'(count), 64'(sz));
      chk({tag, "_full"}, 64'(full), 64'(sz == 8));
      chk({tag, "_rerr"}, 64'(route_err), 64'(m_rerr));
      chk({tag, "_oerr"}, 64'(ovf_err), 64'(m_oerr));
      if (sz == 0) begin
         chk({tag, "_dout"}, 64'(data_out), 64'd0);
         chk({tag, "_label"}, 64'(label), 64'd0);
      end else begin
         chk({tag, "_dout"}, 64'(data_out), 64'(expo(q[0])));
         chk({tag, "_label"}, 64'(label), 64'(route(q[0])));
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge
   task automatic step(input string tag, input logic v, input logic [39:0] d,
                       input logic rdy, input logic rs);
      int  sz;
      logic do_push;
      logic do_pop;
      data_valid = v;
      data_in    = d;
      ready      = rdy;
      rst        = rs;
      if (rs) begin
         q.delete();
         m_rerr = 1'b0;
         m_oerr = 1'b0;
      end else begin
         sz      = q.size();
         do_push = v && (sz < 8);
         do_pop  = 1'b0;
         if (v && sz == 8) m_oerr = 1'b1;
         if (sz != 0) begin
            if (route(q[0]) == 4'b0000) begin
               do_pop = 1'b1;
               m_rerr = 1'b1;
            end else if (rdy) begin
               do_pop = 1'b1;
            end
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [39:0] f;
      int pushed;
      int cyc;
      logic v;

      step("rst0", 1'b0, '0, 1'b0, 1'b1);
      step("rst1", 1'b1, mk(4'b0100, 8'h00), 1'b1, 1'b1);

      // route east: dst x=2,y=0
      f = mk(4'b1000, 8'h11);
      step("r033", 1'b1, f, 1'b0, 1'b0);
      chk("r033_label_e", 64'(label), 64'h4);
      chk("r033_dout", 64'(data_out), 64'(expo(f)));
      step("r033_hold", 1'b0, '0, 1'b0, 1'b0);
      step("r033_pop", 1'b0, '0, 1'b1, 1'b0);

      // fill to full, then overflow attempt
      for (int i = 0; i < 8; i++)
         step("r034_fill", 1'b1, mk((i % 2 == 0) ? 4'b0100 : 4'b0110, 8'(i)), 1'b0, 1'b0);
      chk("r034_full", 64'(full), 64'h1);
      step("r034_ovf", 1'b1, mk(4'b1100, 8'h99), 1'b0, 1'b0);
      chk("r034_cnt8", 64'(count), 64'd8);
      chk("r034_ovf_err", 64'(ovf_err), 64'h1);

      // full with push and pop together: pop only
      step("r035", 1'b1, mk(4'b1000, 8'h77), 1'b1, 1'b0);
      chk("r035_cnt7", 64'(count), 64'd7);
      chk("r035_nfull", 64'(full), 64'h0);
      for (int i = 0; i < 7; i++)
         step("r035_drain", 1'b0, '0, 1'b1, 1'b0);

      // local (1,0) and north (1,2) routes
      step("local", 1'b1, mk(4'b0100, 8'h01), 1'b0, 1'b0);
      chk("local_label", 64'(label), 64'h1);
      step("north", 1'b1, mk(4'b0110, 8'h02), 1'b1, 1'b0);
      chk("north_label", 64'(label), 64'h2);
      step("north_pop", 1'b0, '0, 1'b1, 1'b0);

      // reset clears sticky ovf flag
      step("rst2", 1'b0, '0, 1'b0, 1'b1);

      // unroutable west flit is auto-discarded
      step("r036_push", 1'b1, mk(4'b0000, 8'h03), 1'b0, 1'b0);
      chk("r036_label0", 64'(label), 64'h0);
      step("r036_drop", 1'b0, '0, 1'b0, 1'b0);
      chk("r036_cnt0", 64'(count), 64'd0);
      chk("r036_rerr", 64'(route_err), 64'h1);
      step("r036_sticky", 1'b0, '0, 1'b0, 1'b0);

      // reset mid-operation with push and pop asserted
      step("mid_a", 1'b1, mk(4'b1000, 8'h04), 1'b0, 1'b0);
      step("mid_b", 1'b1, mk(4'b1001, 8'h05), 1'b0, 1'b0);
      step("mid_rst", 1'b1, mk(4'b1010, 8'h06), 1'b1, 1'b1);
      chk("mid_cnt0", 64'(count), 64'd0);

      // 20 flits with random ready; checks order, wrap and timestamps
      pushed = 0;
      cyc = 0;
      while ((pushed < 20 || q.size() != 0) && cyc < 400) begin
         v = (pushed < 20) && (q.size() < 8) && ($urandom_range(0, 3) != 0);
         if (v) begin
            f = mk({2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))},
                   (pushed == 3) ? 8'hFF : (pushed == 7) ? 8'h05 : 8'($urandom));
            pushed++;
         end else begin
            f = '0;
         end
         step("r037", v, f, 1'($urandom_range(0, 1)), 1'b0);
         cyc++;
      end
      chk("r037_pushed", 64'(pushed), 64'd20);
      chk("r037_drained", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
